// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) sharing one memory port with
// a 1-cycle read latency. Data wins by default, but a waiting fetch is served
// after MAX_D_STREAK consecutive data grants.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        RESP_IF,
        RESP_DR,
        RESP_DW
    } resp_state_t;

    resp_state_t state_reg, state_next;
    logic [3:0]  streak_reg, streak_next;

    // Grants are purely combinational so a request is serviced in the cycle it appears.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            d_gnt  = d_req && (!if_req || (streak_reg < STREAK_MAX));
            if_gnt = if_req && !d_gnt;
        end
    end

    // The streak only counts data grants that actually delayed a fetch.
    always_comb begin
        streak_next = streak_reg;
        if (if_gnt || !if_req) begin
            streak_next = 4'd0;
        end else if (d_gnt && (streak_reg < STREAK_MAX)) begin
            streak_next = streak_reg + 4'd1;
        end
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_funct3 = 3'b000;
        mem_wdata  = 32'd0;
        if (if_gnt) begin
            mem_en     = 1'b1;
            mem_addr   = if_addr;
            mem_funct3 = 3'b010;
        end else if (d_gnt) begin
            mem_en     = 1'b1;
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_funct3 = d_funct3;
            mem_wdata  = d_wdata;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (if_gnt) begin
            state_next = RESP_IF;
        end else if (d_gnt) begin
            state_next = d_we ? RESP_DW : RESP_DR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            streak_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
        end
    end

    // Gating with rst drops a response whose grant preceded a reset.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'd0;
        if (!rst) begin
            case (state_reg)
                RESP_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                RESP_DR: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                RESP_DW: begin
                    d_rvalid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
